// File: rtl/result_fifo_arbiter.sv
// result_fifo_arbiter
//   Drains the per-stage result FIFOs into one host transmit stream. The
//   non-empty, host-enabled FIFOs are granted in round-robin order. Each
//   grant sends one framed burst:
//     - a header word {sel[7:0], 8'h00, count[15:0]};
//     - then 'count' data words popped from the granted FIFO, where
//       count = min(usedw, MAX_BURST).
//   tx_last marks the final data word of the frame.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   fifo_empty     : per-FIFO empty flag (show-ahead FIFOs)
//   fifo_usedw     : per-FIFO fill level, USEDW_WIDTH bits each
//   fifo_q         : per-FIFO head word, WIDTH bits each
//   fifo_rdreq     : per-FIFO pop strobe (one-hot or zero)
//   sel_mask       : host enable per FIFO, only looked at while idle
//   tx_valid/tx_data/tx_last/tx_ready : host transmit stream
//   grant_sel      : index of the FIFO currently granted
//   busy           : a frame (header or data) is in progress
module result_fifo_arbiter #(
    parameter int TOTAL_FIFOS = 8,
    parameter int WIDTH       = 32,
    parameter int USEDW_WIDTH = 10,
    parameter int MAX_BURST   = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [TOTAL_FIFOS-1:0]            fifo_empty,
    input  logic [TOTAL_FIFOS*USEDW_WIDTH-1:0] fifo_usedw,
    input  logic [TOTAL_FIFOS*WIDTH-1:0]      fifo_q,
    output logic [TOTAL_FIFOS-1:0]            fifo_rdreq,
    input  logic [TOTAL_FIFOS-1:0]            sel_mask,
    output logic                              tx_valid,
    output logic [WIDTH-1:0]                  tx_data,
    output logic                              tx_last,
    input  logic                              tx_ready,
    output logic [$clog2(TOTAL_FIFOS)-1:0]    grant_sel,
    output logic                              busy
);

    localparam int          SEL_W       = $clog2(TOTAL_FIFOS);
    localparam logic [15:0] MAX_BURST_W = 16'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        BURST
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] last_grant;
    logic [15:0]      count;
    logic [15:0]      remaining;

    logic [TOTAL_FIFOS-1:0] eligible;
    logic                   found;
    logic [SEL_W-1:0]       pick;
    logic [SEL_W-1:0]       cand;
    logic [15:0]            pick_used;
    logic [15:0]            pick_count;

    always_comb begin
        eligible = sel_mask & ~fifo_empty;
        for (int unsigned i = 0; i < TOTAL_FIFOS; i++) begin
            if (fifo_usedw[i*USEDW_WIDTH +: USEDW_WIDTH] == '0) begin
                eligible[i] = 1'b0;
            end
        end
    end

    // Cyclic search starting just after the last grant, so the FIFO served
    // most recently is the last one considered.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= TOTAL_FIFOS; k++) begin
            cand = SEL_W'((32'(last_grant) + k) % TOTAL_FIFOS);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        pick_used  = 16'(fifo_usedw[pick*USEDW_WIDTH +: USEDW_WIDTH]);
        pick_count = (pick_used < MAX_BURST_W) ? pick_used : MAX_BURST_W;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= SEL_W'(TOTAL_FIFOS - 1);
            grant_sel  <= '0;
            count      <= '0;
            remaining  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_sel  <= pick;
                        last_grant <= pick;
                        count      <= pick_count;
                    end
                end
                HEADER: begin
                    if (tx_ready) begin
                        remaining <= count;
                    end
                end
                BURST: begin
                    if (tx_ready) begin
                        remaining <= remaining - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The pop strobe is tied combinationally to the accept, so a stalled
    // word stays at the FIFO head and is presented again.
    always_comb begin
        state_next = state;
        tx_valid   = 1'b0;
        tx_data    = '0;
        tx_last    = 1'b0;
        fifo_rdreq = '0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = HEADER;
                end
            end
            HEADER: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = WIDTH'({8'(grant_sel), 8'h00, count});
                if (tx_ready) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = fifo_q[grant_sel*WIDTH +: WIDTH];
                tx_last  = (remaining == 16'd1);
                if (tx_ready) begin
                    fifo_rdreq[grant_sel] = 1'b1;
                    if (remaining == 16'd1) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_result_fifo_arbiter.sv
// Self-checking bench for result_fifo_arbiter.
// The bench models the FIFOs as queues. A frame-level reference model works
// like this:
//   - When a grant is due, it builds the whole expected frame (header plus
//     data words) from a snapshot of the granted queue.
//   - On each accept, it consumes the next expected word.
// One monitor process compares the DUT outputs against this model every cycle.
module tb_result_fifo_arbiter;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int UW = 10;
    localparam int MB = 16;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    fifo_empty;
    logic [N*UW-1:0] fifo_usedw;
    logic [N*W-1:0]  fifo_q;
    logic [N-1:0]    fifo_rdreq;
    logic [N-1:0]    sel_mask;
    logic            tx_valid;
    logic [W-1:0]    tx_data;
    logic            tx_last;
    logic            tx_ready;
    logic [SW-1:0]   grant_sel;
    logic            busy;

    always #5 clk = ~clk;

    result_fifo_arbiter #(
        .TOTAL_FIFOS(N),
        .WIDTH(W),
        .USEDW_WIDTH(UW),
        .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fifo_empty(fifo_empty),
        .fifo_usedw(fifo_usedw),
        .fifo_q(fifo_q),
        .fifo_rdreq(fifo_rdreq),
        .sel_mask(sel_mask),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_last(tx_last),
        .tx_ready(tx_ready),
        .grant_sel(grant_sel),
        .busy(busy)
    );

    typedef struct packed {
        logic         is_hdr;
        logic         last;
        logic [W-1:0] data;
    } word_t;

    logic [W-1:0]  fq [N][$];
    int            wcnt      [N];
    int            rd_total  [N];
    word_t         exp_q     [$];
    logic [31:0]   hdr_log   [$];
    int            exp_sel    = 0;
    int            last_grant = N - 1;
    int            errors     = 0;
    int            checks     = 0;
    bit            mon_en     = 1'b0;

    // snapshot taken away from the edge, applied just after it
    bit            s_idle;
    bit            s_reset;
    bit            s_ready;
    logic [N-1:0]  s_rdreq;
    bit            found_c;
    int            cand_c;
    int            sz        [N];
    word_t         cur;
    logic [N-1:0]  exp_rd;
    int            cnt;
    logic [31:0]   hdr;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void drive_fifos();
        for (int i = 0; i < N; i++) begin
            fifo_empty[i]          = (fq[i].size() == 0);
            fifo_usedw[i*UW +: UW] = UW'(fq[i].size());
            fifo_q[i*W +: W]       = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endfunction

    function automatic void push(input int f, input int n);
        for (int j = 0; j < n; j++) begin
            fq[f].push_back(W'({8'(f), 24'(wcnt[f])}));
            wcnt[f]++;
        end
        drive_fifos();
    endfunction

    function automatic bit any_elig();
        for (int i = 0; i < N; i++) begin
            if (sel_mask[i] && fq[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // monitor / reference model
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                s_idle = (exp_q.size() == 0);
                if (s_idle) begin
                    chk("idle_valid", W'(tx_valid), '0);
                    chk("idle_busy", W'(busy), '0);
                    chk("idle_data", tx_data, '0);
                    chk("idle_last", W'(tx_last), '0);
                    chk("idle_rdreq", W'(fifo_rdreq), '0);
                end else begin
                    cur    = exp_q[0];
                    exp_rd = '0;
                    if (!cur.is_hdr && tx_ready) exp_rd[exp_sel] = 1'b1;
                    chk("valid", W'(tx_valid), W'(1));
                    chk("busy", W'(busy), W'(1));
                    chk("data", tx_data, cur.data);
                    chk("last", W'(tx_last), W'(cur.last));
                    chk("grant_sel", W'(grant_sel), W'(exp_sel));
                    chk("rdreq", W'(fifo_rdreq), W'(exp_rd));
                end
                s_reset = reset;
                s_ready = tx_ready;
                s_rdreq = fifo_rdreq;
                found_c = 1'b0;
                cand_c  = 0;
                for (int i = 0; i < N; i++) sz[i] = fq[i].size();
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (last_grant + k) % N;
                    if (!found_c && sel_mask[idx] && sz[idx] > 0) begin
                        found_c = 1'b1;
                        cand_c  = idx;
                    end
                end
                @(posedge clk);
                #1;
                if (s_idle && found_c && !s_reset) begin
                    cnt = (sz[cand_c] < MB) ? sz[cand_c] : MB;
                    hdr = {8'(cand_c), 8'h00, 16'(cnt)};
                    exp_q.push_back('{is_hdr: 1'b1, last: 1'b0, data: hdr});
                    for (int j = 0; j < cnt; j++) begin
                        exp_q.push_back('{is_hdr: 1'b0, last: (j == cnt - 1), data: fq[cand_c][j]});
                    end
                    hdr_log.push_back(hdr);
                    exp_sel    = cand_c;
                    last_grant = cand_c;
                end
                for (int i = 0; i < N; i++) begin
                    if (s_rdreq[i]) begin
                        if (fq[i].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL pop_empty: rdreq on empty fifo %0d at %0t", i, $time);
                        end else begin
                            void'(fq[i].pop_front());
                            rd_total[i]++;
                        end
                    end
                end
                if (!s_idle && s_ready) void'(exp_q.pop_front());
                if (s_reset) begin
                    exp_q.delete();
                    last_grant = N - 1;
                end
                drive_fifos();
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || any_elig()) && n < budget) begin
            cyc();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s: drain timeout after %0d cycles", name, n);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    int base;
    int n;

    initial begin
        reset    = 1'b1;
        sel_mask = '1;
        tx_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            wcnt[i]     = 0;
            rd_total[i] = 0;
        end
        drive_fifos();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc();
        chk("rst_grant_sel", W'(grant_sel), '0);
        chk("rst_tx_valid", W'(tx_valid), '0);
        chk("rst_tx_data", tx_data, '0);
        chk("rst_rdreq", W'(fifo_rdreq), '0);
        reset = 1'b0;
        cyc();

        // reset priority: 0 before 3
        hdr_log.delete();
        push(0, 5);
        push(3, 5);
        drain("prio", 200);
        chk("prio_nhdr", W'(hdr_log.size()), W'(2));
        if (hdr_log.size() >= 2) begin
            chk("prio_hdr0", hdr_log[0], 32'h0000_0005);
            chk("prio_hdr1", hdr_log[1], 32'h0300_0005);
        end

        // burst clipping
        hdr_log.delete();
        base = rd_total[2];
        push(2, 40);
        drain("clip", 400);
        chk("clip_nhdr", W'(hdr_log.size()), W'(3));
        if (hdr_log.size() >= 3) begin
            chk("clip_hdr0", hdr_log[0], 32'h0200_0010);
            chk("clip_hdr1", hdr_log[1], 32'h0200_0010);
            chk("clip_hdr2", hdr_log[2], 32'h0200_0008);
        end
        chk("clip_rd", W'(rd_total[2] - base), W'(40));

        // backpressure
        hdr_log.delete();
        base = rd_total[4];
        push(4, 10);
        n = 0;
        while ((exp_q.size() != 0 || any_elig()) && n < 500) begin
            tx_ready = $urandom_range(0, 1) != 0;
            cyc();
            n++;
        end
        if (n >= 500) chk("bp_timeout", W'(n), '0);
        tx_ready = 1'b1;
        cyc();
        chk("bp_rd", W'(rd_total[4] - base), W'(10));
        if (hdr_log.size() >= 1) chk("bp_hdr", hdr_log[0], 32'h0400_000A);

        // masking
        hdr_log.delete();
        sel_mask = 8'b0000_0010;
        for (int i = 0; i < N; i++) push(i, (i == 1) ? 30 : 3);
        repeat (6) cyc();
        sel_mask = '0;
        drain("mask", 200);
        repeat (20) cyc();
        chk("mask_nhdr", W'(hdr_log.size()), W'(1));
        if (hdr_log.size() >= 1) chk("mask_hdr", hdr_log[0], 32'h0100_0010);
        chk("mask_idle", W'(tx_valid), '0);
        sel_mask = '1;
        drain("mask_flush", 1000);

        // reset mid-burst
        pulse_reset();
        hdr_log.delete();
        base = rd_total[0];
        push(0, 8);
        n = 0;
        while (rd_total[0] - base < 3 && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) chk("rmb_timeout", W'(n), '0);
        tx_ready = 1'b0;
        pulse_reset();
        tx_ready = 1'b1;
        chk("rmb_valid", W'(tx_valid), '0);
        chk("rmb_rdreq", W'(fifo_rdreq), '0);
        chk("rmb_busy", W'(busy), '0);
        drain("rmb", 200);
        chk("rmb_rd", W'(rd_total[0] - base), W'(8));
        chk("rmb_nhdr", W'(hdr_log.size()), W'(2));
        if (hdr_log.size() >= 2) chk("rmb_hdr1", hdr_log[1], 32'h0000_0005);

        // fairness
        pulse_reset();
        hdr_log.delete();
        for (int i = 0; i < N; i++) push(i, 20);
        n = 0;
        while (hdr_log.size() < 9 && n < 400) begin
            cyc();
            n++;
        end
        if (n >= 400) chk("fair_timeout", W'(n), '0);
        for (int k = 0; k < 9 && k < hdr_log.size(); k++) begin
            chk("fair_sel", W'(hdr_log[k][31:24]), W'(k % N));
        end
        drain("fair", 2000);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tx_ready = $urandom_range(0, 3) != 0;
            reset    = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 49) == 0) sel_mask = N'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                int f;
                f = $urandom_range(0, N - 1);
                if (fq[f].size() < 100) push(f, $urandom_range(1, 20));
            end
            cyc();
        end
        reset    = 1'b0;
        tx_ready = 1'b1;
        sel_mask = '1;
        drain("rand", 10000);
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
